// File: rtl/pe_feeder.sv
// -----------------------------------------------------------------------------
// pe_feeder
// Transmit-side companion to pe_block. It takes unskewed activation vectors and
// their weights over a valid/ready handshake. It produces the diagonally skewed
// data stream, the broadcast weight, the accumulator clear pulse and the
// pass-data-left control that pe_block consumes. The skew is zero-filled, and
// the pipeline is drained at the end of each tile.
//
// Ports
//   iClk           clock
//   iRst           asynchronous active-high reset
//   iValid         input vector valid
//   oReady         feeder can accept a vector this cycle
//   iData          unskewed vector; array a, lane k at [8*(a*ARRAY_NUM+k) +: 8]
//   iWeight        weight paired with the vector
//   iLast          vector is the last of its tile (sampled on handshake)
//   oData          skewed data to pe_block iData
//   oWeight        weight to pe_block iWeight (latency 1, aligned with lane 0)
//   oClearAcc      accumulator clear pulse, coincident with a tile's first lane-0 word
//   oPassDataLeft  valid tag of lanes 1..ARRAY_NUM-1 as seen on oData
//   oBusy          tile in progress (STREAM or DRAIN)
//   oDone          one-cycle pulse once a tile has been fully emitted
// -----------------------------------------------------------------------------
module pe_feeder #(
    parameter int ARRAY_NUM = 3,
    parameter int BLOCK_NUM = 3
) (
    input  logic                               iClk,
    input  logic                               iRst,
    input  logic                               iValid,
    output logic                               oReady,
    input  logic [8*ARRAY_NUM*BLOCK_NUM-1:0]   iData,
    input  logic [7:0]                         iWeight,
    input  logic                               iLast,
    output logic [8*ARRAY_NUM*BLOCK_NUM-1:0]   oData,
    output logic [7:0]                         oWeight,
    output logic                               oClearAcc,
    output logic [ARRAY_NUM-2:0]               oPassDataLeft,
    output logic                               oBusy,
    output logic                               oDone
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The drain counter counts down from ARRAY_NUM-2 to 0. This gives
    // ARRAY_NUM-1 drain cycles.
    localparam int           CW         = (ARRAY_NUM > 2) ? $clog2(ARRAY_NUM - 1) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'((ARRAY_NUM >= 2) ? (ARRAY_NUM - 2) : 0);

    // With a single lane there is nothing to drain, so the last vector goes straight to DONE.
    function automatic state_t last_target();
        state_t t;
        if (ARRAY_NUM > 1) begin
            t = ST_DRAIN;
        end else begin
            t = ST_DONE;
        end
        return t;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic            ready_s;
    logic            accept_s;
    logic            busy_r;
    logic            done_r;
    logic            clear_r;
    logic [7:0]      weight_r;
    logic [ARRAY_NUM-1:0] tag_r;

    // Ready is held low while reset is high, even though the state is already IDLE.
    assign ready_s  = ~iRst & ((state_r == ST_IDLE) | (state_r == ST_STREAM));
    assign accept_s = iValid & ready_s;

    assign oReady    = ready_s;
    assign oBusy     = busy_r;
    assign oDone     = done_r;
    assign oClearAcc = clear_r;
    assign oWeight   = weight_r;

    // Next-state and drain-counter logic of the tile sequencer.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (iLast) begin
                        next_state_s = last_target();
                        cnt_next_s   = DRAIN_LOAD;
                    end else begin
                        next_state_s = ST_STREAM;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && iLast) begin
                    next_state_s = last_target();
                    cnt_next_s   = DRAIN_LOAD;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = ST_DONE;
                end else begin
                    cnt_next_s   = cnt_r - CW'(1);
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // Sequencer state, drain counter and the registered control outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            clear_r  <= 1'b0;
            weight_r <= 8'd0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= cnt_next_s;
            busy_r   <= (next_state_s == ST_STREAM) | (next_state_s == ST_DRAIN);
            // oDone follows the DONE state by one cycle, so it coincides with the return to IDLE.
            done_r   <= (state_r == ST_DONE);
            clear_r  <= accept_s & (state_r == ST_IDLE);
            if (accept_s) begin
                weight_r <= iWeight;
            end else begin
                weight_r <= weight_r;
            end
        end
    end

    // Valid-tag delay line. Every lane injects the same tag, so stage s of
    // this single line is the tag of lane s at its output.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            tag_r <= {ARRAY_NUM{1'b0}};
        end else begin
            tag_r[0] <= accept_s;
            for (int s = 1; s < ARRAY_NUM; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end
    end

    for (genvar j = 0; j < ARRAY_NUM - 1; j++) begin : g_pass
        assign oPassDataLeft[j] = tag_r[j+1];
    end

    // Per-lane skew: lane k is a (k+1)-deep shift register holding that lane for all arrays.
    // Bubbles inject zeros, so an untagged slot is already 8'd0 at the output.
    for (genvar k = 0; k < ARRAY_NUM; k++) begin : g_lane
        logic [8*BLOCK_NUM-1:0] lane_in_s;
        logic [8*BLOCK_NUM-1:0] dat_r [0:k];

        for (genvar a = 0; a < BLOCK_NUM; a++) begin : g_arr
            assign lane_in_s[8*a +: 8]            = accept_s ? iData[8*(a*ARRAY_NUM+k) +: 8] : 8'd0;
            assign oData[8*(a*ARRAY_NUM+k) +: 8]  = dat_r[k][8*a +: 8];
        end

        // Shift this lane's data by one stage each cycle.
        always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
                for (int i = 0; i <= k; i++) begin
                    dat_r[i] <= '0;
                end
            end else begin
                dat_r[0] <= lane_in_s;
                for (int i = 1; i <= k; i++) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

endmodule
